// File: rtl/jtag_shift_pkg.sv
// Shared types and reset values for the JTAG shift engine.
package jtag_shift_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    RESP = 3'd3,
    TRST = 3'd4
  } state_e;

  localparam logic TMS_RST   = 1'b1;
  localparam logic TDI_RST   = 1'b0;
  localparam logic TRSTN_RST = 1'b1;

endpackage

// File: rtl/jtag_shift_engine_if.sv
// Command/response channel of the JTAG shift engine.
// Adds cmd_trst when JTAG_SHIFT_TRST_EN is defined.
interface jtag_shift_engine_if #(
  parameter int MAX_BITS  = 32,
  parameter int DIV_WIDTH = 8,
  parameter int CNT_W     = $clog2(MAX_BITS + 1)
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CNT_W-1:0]     cmd_len;
  logic [MAX_BITS-1:0]  cmd_tms;
  logic [MAX_BITS-1:0]  cmd_tdi;
  logic                 cmd_capture;
  logic [DIV_WIDTH-1:0] clk_div;
`ifdef JTAG_SHIFT_TRST_EN
  logic                 cmd_trst;
`endif
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [MAX_BITS-1:0]  rsp_tdo;
  logic                 rsp_undriven;

`ifdef JTAG_SHIFT_TRST_EN
  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_capture, clk_div, cmd_trst, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo, rsp_undriven
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_capture, clk_div, cmd_trst, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo, rsp_undriven
  );
`else
  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_capture, clk_div, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo, rsp_undriven
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_capture, clk_div, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo, rsp_undriven
  );
`endif
endinterface

// File: rtl/jtag_tck_phase.sv
// TCK phase timer: counts a half-period down from the loaded divider value.
module jtag_tck_phase #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 phase_done
);
  logic [DIV_WIDTH-1:0] cnt;

  // Down-counter, reloaded at the start of every phase.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= {DIV_WIDTH{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {DIV_WIDTH{1'b0}}) begin
      cnt <= cnt - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign phase_done = (cnt == {DIV_WIDTH{1'b0}});
endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG bit-bang master: shifts TMS/TDI pairs LSB first at a run-time TCK divider and captures TDO.
// Optional TAP reset command enabled by JTAG_SHIFT_TRST_EN.
module jtag_shift_engine
  import jtag_shift_pkg::*;
#(
  parameter int MAX_BITS  = 32,
  parameter int DIV_WIDTH = 8,
  parameter int CNT_W     = $clog2(MAX_BITS + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  jtag_shift_engine_if.slave bus,
  output logic               busy,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  output logic               jtag_TRSTn,
  input  logic               jtag_TDO_data,
  input  logic               jtag_TDO_driven
);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BITS);

  state_e                state, state_nxt;
  logic                  tck, tck_nxt, tms, tms_nxt, tdi, tdi_nxt;
  logic                  rsp_valid, rsp_valid_nxt, undriven, undriven_nxt;
  logic                  capture, capture_nxt;
  logic [MAX_BITS-1:0]   tdo, tdo_nxt, tms_sr, tms_sr_nxt, tdi_sr, tdi_sr_nxt;
  logic [DIV_WIDTH-1:0]  div, div_nxt, phase_val;
  logic [CNT_W-1:0]      idx, idx_nxt, last, last_nxt, len_eff;
  logic                  accept, phase_load, phase_done;
`ifdef JTAG_SHIFT_TRST_EN
  logic                  trstn, trstn_nxt, trst_half, trst_half_nxt;
`endif

  assign bus.cmd_ready = (state == IDLE) && resetn;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign len_eff       = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

  jtag_tck_phase #(.DIV_WIDTH(DIV_WIDTH)) u_phase (
    .clock      (clock),
    .resetn     (resetn),
    .load       (phase_load),
    .load_val   (phase_val),
    .phase_done (phase_done)
  );

  // Next-state and datapath update for the shift FSM.
  always_comb begin
    state_nxt    = state;
    tck_nxt      = tck;
    tms_nxt      = tms;
    tdi_nxt      = tdi;
    undriven_nxt = undriven;
    capture_nxt  = capture;
    tdo_nxt      = tdo;
    tms_sr_nxt   = tms_sr;
    tdi_sr_nxt   = tdi_sr;
    div_nxt      = div;
    idx_nxt      = idx;
    last_nxt     = last;
    phase_load   = 1'b0;
    phase_val    = div;
`ifdef JTAG_SHIFT_TRST_EN
    trstn_nxt     = trstn;
    trst_half_nxt = trst_half;
`endif
    case (state)
      IDLE: begin
        tck_nxt = 1'b0;
        if (accept) begin
          div_nxt      = bus.clk_div;
          capture_nxt  = bus.cmd_capture;
          tdo_nxt      = {MAX_BITS{1'b0}};
          undriven_nxt = 1'b0;
          idx_nxt      = {CNT_W{1'b0}};
          last_nxt     = len_eff - CNT_W'(1);
          phase_load   = 1'b1;
          phase_val    = bus.clk_div;
`ifdef JTAG_SHIFT_TRST_EN
          if (bus.cmd_trst) begin
            trstn_nxt     = 1'b0;
            trst_half_nxt = 1'b0;
            state_nxt     = TRST;
          end else
`endif
          if (len_eff != {CNT_W{1'b0}}) begin
            tms_nxt    = bus.cmd_tms[0];
            tdi_nxt    = bus.cmd_tdi[0];
            tms_sr_nxt = bus.cmd_tms >> 1;
            tdi_sr_nxt = bus.cmd_tdi >> 1;
            state_nxt  = LOW;
          end else if (bus.cmd_capture) begin
            state_nxt = RESP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      LOW: begin
        if (phase_done) begin
          // TDO is sampled on the edge that raises TCK.
          tck_nxt      = 1'b1;
          tdo_nxt      = tdo | (MAX_BITS'(jtag_TDO_driven & jtag_TDO_data) << idx);
          undriven_nxt = undriven | !jtag_TDO_driven;
          phase_load   = 1'b1;
          state_nxt    = HIGH;
        end else begin
          state_nxt = LOW;
        end
      end
      HIGH: begin
        if (phase_done) begin
          tck_nxt = 1'b0;
          if (idx == last) begin
            state_nxt = capture ? RESP : IDLE;
          end else begin
            idx_nxt    = idx + CNT_W'(1);
            tms_nxt    = tms_sr[0];
            tdi_nxt    = tdi_sr[0];
            tms_sr_nxt = tms_sr >> 1;
            tdi_sr_nxt = tdi_sr >> 1;
            phase_load = 1'b1;
            state_nxt  = LOW;
          end
        end else begin
          state_nxt = HIGH;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
`ifdef JTAG_SHIFT_TRST_EN
      TRST: begin
        // TRSTn low spans two phase-timer periods, i.e. one full TCK period.
        if (phase_done) begin
          if (!trst_half) begin
            trst_half_nxt = 1'b1;
            phase_load    = 1'b1;
            state_nxt     = TRST;
          end else begin
            trstn_nxt = 1'b1;
            state_nxt = capture ? RESP : IDLE;
          end
        end else begin
          state_nxt = TRST;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
    rsp_valid_nxt = (state_nxt == RESP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      tck       <= 1'b0;
      tms       <= TMS_RST;
      tdi       <= TDI_RST;
      rsp_valid <= 1'b0;
      undriven  <= 1'b0;
      capture   <= 1'b0;
      tdo       <= {MAX_BITS{1'b0}};
      tms_sr    <= {MAX_BITS{1'b0}};
      tdi_sr    <= {MAX_BITS{1'b0}};
      div       <= {DIV_WIDTH{1'b0}};
      idx       <= {CNT_W{1'b0}};
      last      <= {CNT_W{1'b0}};
`ifdef JTAG_SHIFT_TRST_EN
      trstn     <= TRSTN_RST;
      trst_half <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tck       <= tck_nxt;
      tms       <= tms_nxt;
      tdi       <= tdi_nxt;
      rsp_valid <= rsp_valid_nxt;
      undriven  <= undriven_nxt;
      capture   <= capture_nxt;
      tdo       <= tdo_nxt;
      tms_sr    <= tms_sr_nxt;
      tdi_sr    <= tdi_sr_nxt;
      div       <= div_nxt;
      idx       <= idx_nxt;
      last      <= last_nxt;
`ifdef JTAG_SHIFT_TRST_EN
      trstn     <= trstn_nxt;
      trst_half <= trst_half_nxt;
`endif
    end
  end

  assign busy             = (state != IDLE);
  assign jtag_TCK         = tck;
  assign jtag_TMS         = tms;
  assign jtag_TDI         = tdi;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_tdo      = tdo;
  assign bus.rsp_undriven = undriven;
`ifdef JTAG_SHIFT_TRST_EN
  assign jtag_TRSTn = trstn;
`else
  assign jtag_TRSTn = TRSTN_RST;
`endif
endmodule
